// File: rtl/decode_writeback.sv
// Decode and writeback stage: instruction-to-register-ID decode, the 15-entry
// register file, and the RUN/HALTED/FAULT status machine. Optional macro DECODE_BYPASS_EN.
//
// state        | meaning
// ST_RUN       | executing; stat=AOK, commits write the register file
// ST_HALTED    | halt retired; stat=HLT, sticky until reset
// ST_FAULT_ADR | fetch address error; stat=ADR, sticky until reset
// ST_FAULT_INS | illegal instruction; stat=INS, sticky until reset
module decode_writeback #(
  parameter logic [63:0] RSP_RESET = 64'd1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  regA,
  input  logic [3:0]  regB,
  input  logic        instruct_valid,
  input  logic        mem_error,
  input  logic        cnd,
  input  logic        wb_en,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [1:0]  stat
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  localparam logic [1:0] STAT_INS = 2'd0;
  localparam logic [1:0] STAT_AOK = 2'd1;
  localparam logic [1:0] STAT_HLT = 2'd2;
  localparam logic [1:0] STAT_ADR = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_FAULT_ADR,
    ST_FAULT_INS
  } state_t;

  state_t state;
  state_t next_state;

  logic [63:0] regs [0:14];
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic        commit;

  // ---------------- decode ----------------
  always_comb begin
    srcA = REG_NONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: srcA = regA;
      4'h9, 4'hB:             srcA = REG_RSP;
      default:                srcA = REG_NONE;
    endcase
  end

  always_comb begin
    srcB = REG_NONE;
    case (icode)
      4'h4, 4'h5, 4'h6:       srcB = regB;
      4'h8, 4'h9, 4'hA, 4'hB: srcB = REG_RSP;
      default:                srcB = REG_NONE;
    endcase
  end

  always_comb begin
    dstE = REG_NONE;
    case (icode)
      4'h2:                   dstE = cnd ? regB : REG_NONE;
      4'h3, 4'h6:             dstE = regB;
      4'h8, 4'h9, 4'hA, 4'hB: dstE = REG_RSP;
      default:                dstE = REG_NONE;
    endcase
  end

  always_comb begin
    dstM = REG_NONE;
    case (icode)
      4'h5, 4'hB: dstM = regA;
      default:    dstM = REG_NONE;
    endcase
  end

  // ---------------- status FSM ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == ST_RUN && wb_en) begin
      if (mem_error)           next_state = ST_FAULT_ADR;
      else if (!instruct_valid) next_state = ST_FAULT_INS;
      else if (icode == 4'h0)  next_state = ST_HALTED;
      else                     next_state = ST_RUN;
    end
  end

  always_comb begin
    stat = STAT_AOK;
    case (state)
      ST_RUN:       stat = STAT_AOK;
      ST_HALTED:    stat = STAT_HLT;
      ST_FAULT_ADR: stat = STAT_ADR;
      ST_FAULT_INS: stat = STAT_INS;
      default:      stat = STAT_AOK;
    endcase
  end

  // An instruction that leaves RUN must not write back.
  assign commit = wb_en && (state == ST_RUN) && (next_state == ST_RUN);

  // ---------------- register file ----------------
  // dstM is written last so it overrides dstE when both name the same register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? RSP_RESET : 64'd0;
      end
    end else if (commit) begin
      if (dstE != REG_NONE) regs[dstE] <= valE;
      if (dstM != REG_NONE) regs[dstM] <= valM;
    end
  end

  always_comb begin
    rd_a = 64'd0;
    rd_b = 64'd0;
    if (srcA != REG_NONE) rd_a = regs[srcA];
    if (srcB != REG_NONE) rd_b = regs[srcB];
  end

`ifdef DECODE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = wb_en && (state == ST_RUN);

  always_comb begin
    valA = rd_a;
    if (byp_ok && srcA != REG_NONE) begin
      if (srcA == dstM)      valA = valM;
      else if (srcA == dstE) valA = valE;
    end
  end

  always_comb begin
    valB = rd_b;
    if (byp_ok && srcB != REG_NONE) begin
      if (srcB == dstM)      valB = valM;
      else if (srcB == dstE) valB = valE;
    end
  end
`else
  assign valA = rd_a;
  assign valB = rd_b;
`endif

endmodule

// File: doc/decode_writeback.md
DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 Parameter RSP_RESET, default 64'd1024, is the reset value of %rsp (register 4), the top of the 1 KiB instruction/data memory.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 icode  input  4  instruction code from fetch.
REQ-005 regA  input  4  rA field from fetch.
REQ-006 regB  input  4  rB field from fetch.
REQ-007 instruct_valid  input  1  fetch decoded a legal icode.
REQ-008 mem_error  input  1  fetch PC out of range.
REQ-009 cnd  input  1  condition result from execute; gates rrmovq/cmovXX writeback.
REQ-010 wb_en  input  1  commit strobe: current instruction retires this posedge.
REQ-011 valE  input  64  execute result to write to dstE.
REQ-012 valM  input  64  memory result to write to dstM.
REQ-013 valA  output  64  register read, port A (combinational from srcA).
REQ-014 valB  output  64  register read, port B (combinational from srcB).
REQ-015 srcA, srcB, dstE, dstM  output  4 each  selected register IDs; 4'hF = none.
REQ-016 stat  output  2  processor status: 1=AOK, 2=HLT, 3=ADR, 4 does not fit, so INS=0.

Function
REQ-017 Register file: 15 x 64-bit registers, IDs 0-14; ID 4'hF reads 64'd0, writes to it are dropped.
REQ-018 srcA: regA for icode 2,4,6,A; 4 (%rsp) for icode 9,B; else 4'hF.
REQ-019 srcB: regB for icode 4,5,6; 4 for icode 8,9,A,B; else 4'hF.
REQ-020 dstE: regB for icode 2 when cnd=1 (4'hF when cnd=0); regB for icode 3,6; 4 for icode 8,9,A,B; else 4'hF.
REQ-021 dstM: regA for icode 5,B; else 4'hF.
REQ-022 Decode reads and ID outputs are combinational, zero-latency from inputs.
REQ-023 Writeback: at posedge with wb_en=1 and state RUN, reg[dstE]<=valE and reg[dstM]<=valM; visible to reads the following cycle.
REQ-024 dstE==dstM (popq %rsp): valM wins; valE discarded.
REQ-025 State machine RUN/HALTED/FAULT; stat=AOK in RUN, HLT in HALTED, ADR or INS in FAULT.
REQ-026 RUN transition at posedge with wb_en=1, priority: mem_error -> FAULT(ADR); else !instruct_valid -> FAULT(INS); else icode==0 -> HALTED; else stay RUN.
REQ-027 The instruction causing a transition out of RUN performs no writeback.
REQ-028 HALTED and FAULT are sticky: wb_en ignored, no writes, only reset_n exits.
REQ-029 wb_en=0: no state or register change regardless of other inputs.

Reset
REQ-030 reset_n low asynchronously forces registers 0-14 to 64'd0 except reg[4]=RSP_RESET, and state to RUN (stat=AOK).
REQ-031 Reset asserted mid-cycle aborts any pending writeback; the first write after release occurs on the first posedge with reset_n high and wb_en=1.

Configuration
REQ-032 Macro DECODE_BYPASS_EN defined: when wb_en=1, state RUN and srcA/srcB matches dstM (priority) or dstE (ID != 4'hF), valA/valB return the incoming valM/valE in the same cycle.
REQ-033 Macro undefined: valA/valB always return stored register contents; no bypass logic is built.

Verification
REQ-034 Reset with RSP_RESET=1024; icode=A, regA=0 -> srcA=0, srcB=4, valB=1024, valA=0, stat=AOK.
REQ-035 icode=3, regB=2, valE=64'h1234, wb_en pulse; next cycle icode=2, regA=2 -> valA=64'h1234.
REQ-036 icode=B, regA=4, valE=1032, valM=64'hAA, wb_en -> reg[4]=64'hAA (valM wins).
REQ-037 icode=2, regB=3, cnd=0, valE=5, wb_en -> dstE=4'hF, reg[3] unchanged; repeat with cnd=1 -> reg[3]=5.
REQ-038 mem_error=1 with wb_en -> stat=ADR, no write; later icode=3 with wb_en -> still ADR, no write; reset_n low -> AOK, registers cleared.
REQ-039 With DECODE_BYPASS_EN: icode=6, regA=regB=1, wb_en, dstE=1, valE=7 -> valA=valB=7 in the same cycle; without the macro -> old value.
